// File: rtl/multi_mode_ff_bank_if.sv
// Bus bundle for multi_mode_ff_bank: control/data inputs and state/status outputs.
interface multi_mode_ff_bank_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic             mode_ld;
  logic [1:0]       mode_in;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic [1:0]       mode;
  logic             busy;
  logic             invalid;
  logic             err_sticky;
  logic [CNT_W-1:0] err_cnt;

  // Driver side: issues mode loads and per-channel inputs, observes state.
  modport master (
    output mode_ld, mode_in, en, a, b, clr_err,
    input  q, q_bar, mode, busy, invalid, err_sticky, err_cnt
  );

  // Flip-flop bank side.
  modport slave (
    input  mode_ld, mode_in, en, a, b, clr_err,
    output q, q_bar, mode, busy, invalid, err_sticky, err_cnt
  );
endinterface

// File: rtl/multi_mode_ff_bank.sv
// WIDTH-bit flip-flop bank with a shared runtime mode (SR/JK/D/T), registered
// SR forbidden-input detection, sticky error flag and a one-cycle guard after
// every mode load. Optional saturating invalid-event counter: ERR_COUNT_EN.
module multi_mode_ff_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_mode_ff_bank_if.slave   bus
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_GUARD = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             invalid_q, invalid_d;
  logic             err_q, err_d;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a mode load always costs exactly one guard cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.mode_ld) state_d = ST_GUARD;
      ST_GUARD: state_d = ST_RUN;
    endcase
  end

  // Next values of bank state, mode and status; mode_ld takes priority over en
  always_comb begin
    q_d       = q_q;
    mode_d    = mode_q;
    busy_d    = (state_d == ST_GUARD);
    invalid_d = 1'b0;
    if (state_q == ST_RUN) begin
      if (bus.mode_ld) begin
        mode_d = bus.mode_in;
      end else if (bus.en) begin
        case (mode_q)
          // set where a&~b, clear where ~a&b, hold on 00 and forbidden 11
          MODE_SR: begin
            q_d       = (q_q & (bus.a | ~bus.b)) | (bus.a & ~bus.b);
            invalid_d = |(bus.a & bus.b);
          end
          MODE_JK: q_d = (bus.a & ~q_q) | (~bus.b & q_q);
          MODE_D:  q_d = bus.a;
          MODE_T:  q_d = q_q ^ bus.a;
        endcase
      end
    end
    // a new event outranks a simultaneous clear
    err_d = err_q;
    if (invalid_d) begin
      err_d = 1'b1;
    end else if (bus.clr_err) begin
      err_d = 1'b0;
    end
  end

  // Bank and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q       <= WIDTH'(0);
      mode_q    <= MODE_SR;
      busy_q    <= 1'b0;
      invalid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      q_q       <= q_d;
      mode_q    <= mode_d;
      busy_q    <= busy_d;
      invalid_q <= invalid_d;
      err_q     <= err_d;
    end
  end

`ifdef ERR_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating per-event count; clear together with an event restarts at one
  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_err) begin
      cnt_d = invalid_d ? CNT_W'(1) : CNT_W'(0);
    end else if (invalid_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_W'(0);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.err_cnt = cnt_q;
`else
  assign bus.err_cnt = CNT_W'(0);
`endif

  assign bus.q          = q_q;
  assign bus.q_bar      = ~q_q;
  assign bus.mode       = mode_q;
  assign bus.busy       = busy_q;
  assign bus.invalid    = invalid_q;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Self-checking bench for multi_mode_ff_bank: directed scenarios plus a
// randomized run against a per-bit behavioural model.
module tb_multi_mode_ff_bank;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  multi_mode_ff_bank_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  multi_mode_ff_bank #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model state
  logic [W-1:0] m_q;
  logic [1:0]   m_mode;
  bit           m_guard, m_inv, m_sticky;
  int           m_cnt;

  task automatic model_reset();
    m_q = '0; m_mode = 2'd0; m_guard = 0; m_inv = 0; m_sticky = 0; m_cnt = 0;
  endtask

  // Apply the rules for one clock edge using the inputs currently driven
  task automatic model_step();
    bit ev;
    bit was_guard;
    ev = 0;
    was_guard = m_guard;
    m_guard = 0;
    if (!was_guard) begin
      if (bus.mode_ld) begin
        m_mode  = bus.mode_in;
        m_guard = 1;
      end else if (bus.en) begin
        for (int i = 0; i < W; i++) begin
          bit s, r;
          s = bus.a[i];
          r = bus.b[i];
          case (m_mode)
            2'd0: if (s && r) ev = 1; else if (s) m_q[i] = 1'b1; else if (r) m_q[i] = 1'b0;
            2'd1: if (s && r) m_q[i] = ~m_q[i]; else if (s) m_q[i] = 1'b1; else if (r) m_q[i] = 1'b0;
            2'd2: m_q[i] = s;
            default: if (s) m_q[i] = ~m_q[i];
          endcase
        end
      end
    end
    m_inv = ev;
    if (ev) m_sticky = 1;
    else if (bus.clr_err) m_sticky = 0;
`ifdef ERR_COUNT_EN
    if (bus.clr_err) m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < (1 << CW) - 1) m_cnt++;
`else
    m_cnt = 0;
`endif
  endtask

  task automatic drive(input bit ld, input logic [1:0] mi, input bit e,
                       input logic [W-1:0] av, input logic [W-1:0] bv, input bit clr);
    bus.mode_ld = ld; bus.mode_in = mi; bus.en = e; bus.a = av; bus.b = bv; bus.clr_err = clr;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mode(input logic [1:0] mi);
    drive(1, mi, 0, '0, '0, 0); tick();
    drive(0, 2'd0, 0, '0, '0, 0); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 2'd0, 0, '0, '0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", bus.q); end
    total++; if (bus.q_bar !== 8'hFF) begin bad++; $display("FAIL reset_qbar got=%h exp=FF", bus.q_bar); end
    total++; if (bus.mode !== 2'b00 || bus.busy !== 1'b0 || bus.invalid !== 1'b0)
      begin bad++; $display("FAIL reset_ctrl mode=%b busy=%b inv=%b exp 00/0/0", bus.mode, bus.busy, bus.invalid); end
    total++; if (bus.err_sticky !== 1'b0 || bus.err_cnt !== '0)
      begin bad++; $display("FAIL reset_err sticky=%b cnt=%0d exp 0/0", bus.err_sticky, bus.err_cnt); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sr();
    drive(0, 2'd0, 1, 8'h0F, 8'h00, 0); tick();
    total++; if (bus.q !== 8'h0F || bus.q_bar !== 8'hF0) begin bad++; $display("FAIL sr_set q=%h qb=%h exp 0F/F0", bus.q, bus.q_bar); end
    drive(0, 2'd0, 1, 8'h00, 8'h03, 0); tick();
    total++; if (bus.q !== 8'h0C) begin bad++; $display("FAIL sr_clr q=%h exp 0C", bus.q); end
    drive(0, 2'd0, 1, 8'h01, 8'h01, 0); tick();
    total++; if (bus.q !== 8'h0C) begin bad++; $display("FAIL sr_forbid_q q=%h exp 0C", bus.q); end
    total++; if (bus.invalid !== 1'b1 || bus.err_sticky !== 1'b1)
      begin bad++; $display("FAIL sr_forbid_flag inv=%b sticky=%b exp 1/1", bus.invalid, bus.err_sticky); end
    drive(0, 2'd0, 0, 8'h01, 8'h01, 0); tick();
    total++; if (bus.invalid !== 1'b0 || bus.err_sticky !== 1'b1)
      begin bad++; $display("FAIL sr_pulse inv=%b sticky=%b exp 0/1", bus.invalid, bus.err_sticky); end
  endtask

  task automatic test_mode_change();
    drive(1, 2'd1, 1, 8'hFF, 8'h00, 0); tick();
    total++; if (bus.q !== 8'h0C || bus.busy !== 1'b1 || bus.mode !== 2'b01)
      begin bad++; $display("FAIL mode_ld q=%h busy=%b mode=%b exp 0C/1/01", bus.q, bus.busy, bus.mode); end
    drive(1, 2'd3, 1, 8'hFF, 8'hFF, 0); tick();
    total++; if (bus.q !== 8'h0C || bus.busy !== 1'b0 || bus.mode !== 2'b01 || bus.invalid !== 1'b0)
      begin bad++; $display("FAIL guard q=%h busy=%b mode=%b inv=%b exp 0C/0/01/0", bus.q, bus.busy, bus.mode, bus.invalid); end
    drive(0, 2'd0, 1, 8'hFF, 8'hFF, 0); tick();
    total++; if (bus.q !== 8'hF3 || bus.invalid !== 1'b0)
      begin bad++; $display("FAIL jk_toggle q=%h inv=%b exp F3/0", bus.q, bus.invalid); end
  endtask

  task automatic test_d_t();
    load_mode(2'd2);
    drive(0, 2'd0, 1, 8'h5A, 8'hFF, 0); tick();
    total++; if (bus.q !== 8'h5A) begin bad++; $display("FAIL d_load q=%h exp 5A", bus.q); end
    load_mode(2'd3);
    drive(0, 2'd0, 1, 8'h0F, 8'hFF, 0); tick();
    total++; if (bus.q !== 8'h55) begin bad++; $display("FAIL t_toggle q=%h exp 55", bus.q); end
    drive(0, 2'd0, 0, 8'hFF, 8'hFF, 0); tick();
    total++; if (bus.q !== 8'h55) begin bad++; $display("FAIL en_hold q=%h exp 55", bus.q); end
  endtask

  task automatic test_no_invalid();
    for (int m = 1; m < 4; m++) begin
      load_mode(2'(m));
      drive(0, 2'd0, 1, 8'hFF, 8'hFF, 0); tick();
      total++; if (bus.invalid !== 1'b0) begin bad++; $display("FAIL no_inv_mode%0d inv=%b exp 0", m, bus.invalid); end
    end
  endtask

  task automatic test_err_count();
    int exp_sat, exp_one;
`ifdef ERR_COUNT_EN
    exp_sat = 3; exp_one = 1;
`else
    exp_sat = 0; exp_one = 0;
`endif
    load_mode(2'd0);
    drive(0, 2'd0, 0, '0, '0, 1); tick();
    total++; if (bus.err_sticky !== 1'b0 || bus.err_cnt !== '0)
      begin bad++; $display("FAIL clr_pre sticky=%b cnt=%0d exp 0/0", bus.err_sticky, bus.err_cnt); end
    repeat (5) begin drive(0, 2'd0, 1, 8'h81, 8'h01, 0); tick(); end
    total++; if (bus.err_cnt !== CW'(exp_sat)) begin bad++; $display("FAIL cnt_sat cnt=%0d exp %0d", bus.err_cnt, exp_sat); end
    drive(0, 2'd0, 1, 8'h01, 8'h01, 1); tick();
    total++; if (bus.err_cnt !== CW'(exp_one) || bus.err_sticky !== 1'b1)
      begin bad++; $display("FAIL clr_with_event cnt=%0d sticky=%b exp %0d/1", bus.err_cnt, bus.err_sticky, exp_one); end
    drive(0, 2'd0, 1, 8'h00, 8'h00, 1); tick();
    total++; if (bus.err_cnt !== '0 || bus.err_sticky !== 1'b0)
      begin bad++; $display("FAIL clr_alone cnt=%0d sticky=%b exp 0/0", bus.err_cnt, bus.err_sticky); end
  endtask

  task automatic test_async_reset();
    load_mode(2'd2);
    drive(0, 2'd0, 1, 8'hA5, 8'h00, 0); tick();
    total++; if (bus.q !== 8'hA5) begin bad++; $display("FAIL pre_rst q=%h exp A5", bus.q); end
    #2 rst = 1'b1;
    #1;
    total++; if (bus.q !== 8'h00 || bus.q_bar !== 8'hFF || bus.mode !== 2'b00)
      begin bad++; $display("FAIL async_rst q=%h qb=%h mode=%b exp 00/FF/00", bus.q, bus.q_bar, bus.mode); end
    drive(0, 2'd0, 0, '0, '0, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
            W'($urandom), W'($urandom), ($urandom_range(0, 9) == 0));
      tick();
      total++; if (bus.q !== m_q) begin bad++; $display("FAIL rnd_q it=%0d got=%h exp=%h", n, bus.q, m_q); end
      total++; if (bus.q_bar !== ~m_q) begin bad++; $display("FAIL rnd_qbar it=%0d got=%h exp=%h", n, bus.q_bar, ~m_q); end
      total++; if (bus.mode !== m_mode || bus.busy !== m_guard)
        begin bad++; $display("FAIL rnd_ctrl it=%0d mode=%b busy=%b exp %b/%b", n, bus.mode, bus.busy, m_mode, m_guard); end
      total++; if (bus.invalid !== m_inv || bus.err_sticky !== m_sticky)
        begin bad++; $display("FAIL rnd_err it=%0d inv=%b sticky=%b exp %b/%b", n, bus.invalid, bus.err_sticky, m_inv, m_sticky); end
      total++; if (bus.err_cnt !== CW'(m_cnt)) begin bad++; $display("FAIL rnd_cnt it=%0d got=%0d exp=%0d", n, bus.err_cnt, m_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_sr();
    test_mode_change();
    test_d_t();
    test_no_invalid();
    test_err_count();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
